// File: rtl/weight_loader.sv
// Streams one kernel of KERN_S coefficients from an ap_fifo into a local buffer and serves registered reads.
// Define WEIGHT_LOADER_PINGPONG_EN for double buffering: reads keep hitting the old kernel while the new one loads.
module weight_loader #(
  parameter int KERN_S  = 9,
  parameter int COEFF_W = 16
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic [COEFF_W-1:0]        input_V_dout,
  input  logic                      input_V_empty_n,
  output logic                      input_V_read,
  input  logic                      start,
  input  logic                      rd_en,
  input  logic [$clog2(KERN_S)-1:0] rd_addr,
  output logic [COEFF_W-1:0]        rd_data,
  output logic                      rd_valid,
  output logic                      weights_ready,
  output logic                      busy,
  output logic                      load_done,
  output logic                      bank_sel
);

  localparam int                ADDR_W   = $clog2(KERN_S);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(KERN_S - 1);
  localparam logic [ADDR_W:0]   ADDR_LIM = (ADDR_W + 1)'(KERN_S);

  typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [ADDR_W-1:0]  wr_cnt;
  logic               pop;
  logic               last_pop;
  logic               start_load;
  logic               rd_accept;
  logic               rd_in_range;
  logic [COEFF_W-1:0] mem_word;

  assign pop          = (state == LOAD) && input_V_empty_n;
  assign last_pop     = pop && (wr_cnt == LAST_IDX);
  assign start_load   = (state != LOAD) && start;
  assign input_V_read = pop;
  assign busy         = (state == LOAD);
  assign rd_accept    = rd_en && weights_ready;
  assign rd_in_range  = {1'b0, rd_addr} < ADDR_LIM;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, READY: if (start) state_nxt = LOAD;
      LOAD:        if (last_pop) state_nxt = READY;
      default:     state_nxt = IDLE;
    endcase
  end

  // Counter wraps to 0 on the final pop so it never points past the kernel.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_cnt    <= '0;
      load_done <= 1'b0;
    end else begin
      load_done <= last_pop;
      if (start_load) begin
        wr_cnt <= '0;
      end else if (pop) begin
        wr_cnt <= last_pop ? '0 : wr_cnt + 1'b1;
      end
    end
  end

`ifdef WEIGHT_LOADER_PINGPONG_EN
  logic [COEFF_W-1:0] mem [2][KERN_S];

  // The new kernel fills the idle bank; the swap lands on the same edge the load completes.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      weights_ready <= 1'b0;
      bank_sel      <= 1'b0;
    end else if (last_pop) begin
      weights_ready <= 1'b1;
      bank_sel      <= ~bank_sel;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (pop) mem[~bank_sel][wr_cnt] <= input_V_dout;
  end

  assign mem_word = mem[bank_sel][rd_addr];
`else
  logic [COEFF_W-1:0] mem [KERN_S];

  // Single buffer: the old kernel is being overwritten, so it stops being readable at start.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      weights_ready <= 1'b0;
    end else if (start_load) begin
      weights_ready <= 1'b0;
    end else if (last_pop) begin
      weights_ready <= 1'b1;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (pop) mem[wr_cnt] <= input_V_dout;
  end

  assign bank_sel = 1'b0;
  assign mem_word = mem[rd_addr];
`endif

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_accept;
      if (rd_accept) begin
        rd_data <= rd_in_range ? mem_word : '0;
      end
    end
  end

endmodule

// File: tb/tb_weight_loader.sv
// Self-checking bench for weight_loader (KERN_S=4, COEFF_W=8); a second KERN_S=5 instance covers out-of-range reads.
// Read expectations go into a scoreboard queue when issued and are popped by a monitor when rd_valid appears.
module tb_weight_loader;

  localparam int KS = 4;
  localparam int CW = 8;
`ifdef WEIGHT_LOADER_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic          ap_clk;
  logic          ap_rst_n;
  logic [CW-1:0] input_V_dout;
  logic          input_V_empty_n;
  logic          input_V_read;
  logic          start;
  logic          rd_en;
  logic [1:0]    rd_addr;
  logic [CW-1:0] rd_data;
  logic          rd_valid;
  logic          weights_ready;
  logic          busy;
  logic          load_done;
  logic          bank_sel;

  logic          w5_start;
  logic [CW-1:0] w5_dout;
  logic          w5_empty_n;
  logic          w5_read;
  logic          w5_rd_en;
  logic [2:0]    w5_rd_addr;
  logic [CW-1:0] w5_rd_data;
  logic          w5_rd_valid;
  logic          w5_ready;
  logic          w5_busy;
  logic          w5_load_done;
  logic          w5_bank_sel;

  weight_loader #(.KERN_S(KS), .COEFF_W(CW)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .input_V_dout(input_V_dout), .input_V_empty_n(input_V_empty_n), .input_V_read(input_V_read),
    .start(start), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .weights_ready(weights_ready), .busy(busy), .load_done(load_done), .bank_sel(bank_sel)
  );

  weight_loader #(.KERN_S(5), .COEFF_W(CW)) dut5 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .input_V_dout(w5_dout), .input_V_empty_n(w5_empty_n), .input_V_read(w5_read),
    .start(w5_start), .rd_en(w5_rd_en), .rd_addr(w5_rd_addr), .rd_data(w5_rd_data), .rd_valid(w5_rd_valid),
    .weights_ready(w5_ready), .busy(w5_busy), .load_done(w5_load_done), .bank_sel(w5_bank_sel)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int            n_cmp;
  int            n_fail;
  logic [CW-1:0] exp_q[$];
  logic [CW-1:0] model_mem [2][KS];
  bit            exp_bank;
  bit            exp_ready;
  logic [CW-1:0] last_rd;
  logic [CW-1:0] mon_exp;

  always @(negedge ap_clk) begin
    if (ap_rst_n && rd_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL unexpected_rd_valid: got rd_valid=1 (rd_data=%02h) expected no result", rd_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rd_data !== mon_exp) begin
          n_fail++;
          $display("[TB] FAIL read_data: got %02h expected %02h", rd_data, mon_exp);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic clk1();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic read_burst(input logic [15:0] addrs, input int n);
    for (int i = 0; i < n; i++) begin
      rd_en   = 1'b1;
      rd_addr = addrs[2*i +: 2];
      if (exp_ready) begin
        exp_q.push_back(model_mem[exp_bank][rd_addr]);
        last_rd = model_mem[exp_bank][rd_addr];
      end
      clk1();
    end
    rd_en = 1'b0;
    clk1();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL read_drain: got %0d pending results expected 0", exp_q.size());
      exp_q.delete();
    end
    n_cmp++;
    if (rd_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL idle_rd_valid: got %b expected 0", rd_valid);
    end
  endtask

  task automatic run_load(input logic [CW-1:0] w0, w1, w2, w3, input logic [31:0] stall_mask);
    logic [CW-1:0] w [KS];
    bit            pre_ready;
    bit            wb;
    int            idx;
    int            cyc;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    start           = 1'b1;
    input_V_empty_n = 1'b1;
    input_V_dout    = w0;
    exp_ready       = PP ? exp_ready : 1'b0;
    pre_ready       = exp_ready;
    #1;
    n_cmp++;
    if (input_V_read !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL pop_outside_load: got %b expected 0", input_V_read);
    end
    clk1();
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL busy_in_load: got %b expected 1", busy);
    end
    idx = 0;
    cyc = 0;
    while (idx < KS && cyc < 64) begin
      input_V_empty_n = (cyc < 32) ? !stall_mask[cyc] : 1'b1;
      input_V_dout    = w[idx];
      #1;
      n_cmp++;
      if (input_V_read !== input_V_empty_n) begin
        n_fail++;
        $display("[TB] FAIL pop_strobe: cycle %0d got %b expected %b", cyc, input_V_read, input_V_empty_n);
      end
      n_cmp++;
      if (weights_ready !== pre_ready) begin
        n_fail++;
        $display("[TB] FAIL ready_during_load: cycle %0d got %b expected %b", cyc, weights_ready, pre_ready);
      end
      n_cmp++;
      if (load_done !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL early_load_done: cycle %0d got %b expected 0", cyc, load_done);
      end
      @(posedge ap_clk);
      #1;
      if (input_V_empty_n) idx++;
      cyc++;
    end
    input_V_empty_n = 1'b0;
    n_cmp++;
    if (idx < KS) begin
      n_fail++;
      $display("[TB] FAIL load_timeout: got %0d pops expected %0d", idx, KS);
    end
    wb = PP ? ~exp_bank : 1'b0;
    for (int i = 0; i < KS; i++) model_mem[wb][i] = w[i];
    exp_bank  = PP ? ~exp_bank : 1'b0;
    exp_ready = 1'b1;
    n_cmp++;
    if ({load_done, busy, weights_ready, bank_sel} !== {1'b1, 1'b0, 1'b1, exp_bank}) begin
      n_fail++;
      $display("[TB] FAIL load_complete: got done/busy/ready/bank=%b%b%b%b expected 101%b",
               load_done, busy, weights_ready, bank_sel, exp_bank);
    end
    clk1();
    n_cmp++;
    if (load_done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL load_done_pulse: got %b expected 0", load_done);
    end
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b1;
    start = 1'b0; rd_en = 1'b0; rd_addr = '0; input_V_dout = '0; input_V_empty_n = 1'b1;
    w5_start = 1'b0; w5_dout = '0; w5_empty_n = 1'b0; w5_rd_en = 1'b0; w5_rd_addr = '0;
    exp_bank = 1'b0; exp_ready = 1'b0; last_rd = '0;
    #3 ap_rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, input_V_read, rd_valid, weights_ready, load_done, bank_sel} !== 6'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_flags: got busy/read/valid/ready/done/bank=%b%b%b%b%b%b expected 000000",
               busy, input_V_read, rd_valid, weights_ready, load_done, bank_sel);
    end
    n_cmp++;
    if (rd_data !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL reset_rd_data: got %02h expected 00", rd_data);
    end
    clk1();
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    clk1();
    n_cmp++;
    if ({busy, input_V_read} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL idle_after_reset: got busy/read=%b%b expected 00", busy, input_V_read);
    end
  endtask

  task automatic test_read_before_load();
    rd_en = 1'b1; rd_addr = 2'd0;
    clk1();
    rd_addr = 2'd3;
    clk1();
    rd_en = 1'b0;
    n_cmp++;
    if ({rd_valid, rd_data} !== {1'b0, 8'h00}) begin
      n_fail++;
      $display("[TB] FAIL read_not_ready: got valid=%b data=%02h expected valid=0 data=00", rd_valid, rd_data);
    end
    clk1();
  endtask

  task automatic test_basic_load();
    run_load(8'h11, 8'h22, 8'h33, 8'h44, 32'h0);
  endtask

  task automatic test_back_to_back();
    read_burst(16'h63E4, 8);
  endtask

  task automatic test_stall_load();
    run_load(8'h11, 8'h22, 8'h33, 8'h44, 32'b100110);
    read_burst(16'h00E4, 4);
  endtask

  task automatic test_reset_mid_load();
    start = 1'b1; input_V_empty_n = 1'b1; input_V_dout = 8'h77;
    clk1();
    start = 1'b0;
    clk1();
    input_V_dout = 8'h78;
    clk1();
    #2 ap_rst_n = 1'b0;
    #1;
    exp_ready = 1'b0; exp_bank = 1'b0; last_rd = 8'h00;
    n_cmp++;
    if ({busy, input_V_read, rd_valid, weights_ready, load_done, bank_sel, rd_data} !== 14'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_load: got busy/read/valid/ready/done/bank=%b%b%b%b%b%b data=%02h expected all 0",
               busy, input_V_read, rd_valid, weights_ready, load_done, bank_sel, rd_data);
    end
    clk1();
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      clk1();
      n_cmp++;
      if ({busy, input_V_read, weights_ready} !== 3'b000) begin
        n_fail++;
        $display("[TB] FAIL no_pop_after_reset: got busy/read/ready=%b%b%b expected 000",
                 busy, input_V_read, weights_ready);
      end
    end
    run_load(8'hA0, 8'hA1, 8'hA2, 8'hA3, 32'h0);
    read_burst(16'h00E4, 4);
  endtask

  task automatic test_reload_during_reads();
    run_load(8'hC1, 8'hC2, 8'hC3, 8'hC4, 32'h0);
    read_burst(16'h00E4, 4);
    fork
      run_load(8'hD1, 8'hD2, 8'hD3, 8'hD4, 32'h7E);
      begin
        bit acc;
        clk1();
        for (int i = 0; i < KS; i++) begin
          rd_en   = 1'b1;
          rd_addr = 2'(i);
          start   = (i == 1);
          acc     = exp_ready;
          if (acc) begin
            exp_q.push_back(model_mem[exp_bank][i]);
            last_rd = model_mem[exp_bank][i];
          end
          clk1();
          start = 1'b0;
          n_cmp++;
          if ({rd_valid, weights_ready, rd_data} !== {acc, PP, last_rd}) begin
            n_fail++;
            $display("[TB] FAIL read_in_load: got valid=%b ready=%b data=%02h expected valid=%b ready=%b data=%02h",
                     rd_valid, weights_ready, rd_data, acc, PP, last_rd);
          end
        end
        rd_en = 1'b0;
        clk1();
      end
    join
    read_burst(16'h00E4, 4);
  endtask

  task automatic test_out_of_range();
    logic [2:0]    addr_tab [3];
    logic [CW-1:0] data_tab [3];
    addr_tab = '{3'd4, 3'd5, 3'd7};
    data_tab = '{8'h64, 8'h00, 8'h00};
    w5_start = 1'b1; w5_empty_n = 1'b1; w5_dout = 8'h60;
    clk1();
    w5_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      w5_dout = 8'(8'h60 + i);
      clk1();
    end
    w5_empty_n = 1'b0;
    n_cmp++;
    if ({w5_load_done, w5_ready} !== 2'b11) begin
      n_fail++;
      $display("[TB] FAIL k5_load: got done/ready=%b%b expected 11", w5_load_done, w5_ready);
    end
    for (int i = 0; i < 3; i++) begin
      w5_rd_en = 1'b1; w5_rd_addr = addr_tab[i];
      clk1();
      n_cmp++;
      if ({w5_rd_valid, w5_rd_data} !== {1'b1, data_tab[i]}) begin
        n_fail++;
        $display("[TB] FAIL k5_read_addr%0d: got valid=%b data=%02h expected valid=1 data=%02h",
                 addr_tab[i], w5_rd_valid, w5_rd_data, data_tab[i]);
      end
    end
    w5_rd_en = 1'b0;
    clk1();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_read_before_load();
    test_basic_load();
    test_back_to_back();
    test_stall_load();
    test_reset_mid_load();
    test_reload_during_reads();
    test_out_of_range();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
